sram_word_controller: RTL and testbench

- Downstream memory stage of the cache controller; services its 32-bit word read/write requests on the 16-bit external SRAM.
- Each word occupies two consecutive SRAM halfwords. The low half is at the even SRAM address and the high half is at the odd address.
- Each halfword access is held for a fixed number of wait cycles.
- `ready` freezes the requester for the whole transaction.

---
 rtl/sram_word_controller.sv | 86 ++++++++
 tb/tb_sram_word_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_controller.sv
// sram_word_controller: services 32-bit word reads/writes as two timed halfword accesses
// on a 16-bit asynchronous SRAM (low half at the even address, high half at the odd one).
module sram_word_controller #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [16:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [15:0]   r_lo;
    logic [16:0]   w_word;
    logic          w_last, w_write, w_read, w_hi, w_req;

    // Offset wraps modulo 2^32; only bits [18:2] select the SRAM word
    assign w_word  = 17'((address - ADDR_BASE) >> 2);
    assign w_req   = rd_en | wr_en;
    assign w_last  = r_cnt == CW'(WAIT_CYCLES - 1);
    assign w_write = (r_state == WR_LO) || (r_state == WR_HI);
    assign w_read  = (r_state == RD_LO) || (r_state == RD_HI);
    assign w_hi    = (r_state == WR_HI) || (r_state == RD_HI);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? (wr_en ? WR_LO : RD_LO) : IDLE;
            WR_LO:   w_next = w_last ? WR_HI : WR_LO;
            WR_HI:   w_next = w_last ? DONE : WR_HI;
            RD_LO:   w_next = w_last ? RD_HI : RD_LO;
            RD_HI:   w_next = w_last ? DONE : RD_HI;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_lo     <= '0;
            readData <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= ((w_write || w_read) && !w_last) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && w_req) begin
                r_addr  <= w_word;
                r_wdata <= writeData;
            end
            if (r_state == RD_LO && w_last)
                r_lo <= SRAM_DQ;
            if (r_state == RD_HI && w_last)
                readData <= {SRAM_DQ, r_lo};
        end
    end

    // WE_N rises in the last cycle of each write half so the SRAM latches on stable address/data
    assign ready     = (r_state == IDLE) ? ~w_req : (r_state == DONE);
    assign SRAM_ADDR = {r_addr, w_hi};
    assign SRAM_WE_N = ~w_write | w_last;
    assign SRAM_OE_N = ~w_read;
    assign SRAM_DQ   = w_write ? (w_hi ? r_wdata[31:16] : r_wdata[15:0]) : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
endmodule

// File: tb/tb_sram_word_controller.sv
// tb_sram_word_controller: directed checks of the word controller against a small SRAM model,
// plus a second instance with WAIT_CYCLES = 2 for timing and address-wrap behaviour.
module tb_sram_word_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic [31:0] readData;
    logic        ready;
    wire  [15:0] dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, ce_n, we_n, oe_n;

    logic        wr2 = 1'b0, rd2 = 1'b0;
    logic [31:0] address2 = '0, writeData2 = '0;
    logic [31:0] readData2;
    logic        ready2;
    wire  [15:0] dq2;
    logic [17:0] sram_addr2;
    logic        ub2, lb2, ce2, we2, oe2;

    logic [15:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    sram_word_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .SRAM_DQ(dq),
        .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
    );

    sram_word_controller #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(address2),
        .writeData(writeData2), .readData(readData2), .ready(ready2), .SRAM_DQ(dq2),
        .SRAM_ADDR(sram_addr2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_CE_N(ce2),
        .SRAM_WE_N(we2), .SRAM_OE_N(oe2)
    );

    // SRAM model: drives on OE low, latches on the WE rising edge
    assign dq  = !oe_n ? mem[sram_addr[5:0]] : 16'bz;
    assign dq2 = !oe2 ? 16'h5A5A : 16'bz;
    always @(posedge we_n) mem[sram_addr[5:0]] <= dq;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if ({we_n, oe_n} !== 2'b11) begin errors++; $display("FAIL reset_we_oe got=%b exp=11", {we_n, oe_n}); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
        checks++; if (readData !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", readData); end
        checks++; if ({ub_n, lb_n, ce_n} !== 3'b000) begin errors++; $display("FAIL reset_enables got=%b exp=000", {ub_n, lb_n, ce_n}); end
        rd_en = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready_req got=%b exp=0", ready); end
        rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write;
        address = 32'd1032; writeData = 32'hDEADBEEF; wr_en = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wr_req_ready got=%b exp=0", ready); end
        for (int i = 0; i < 6; i++) begin
            logic [36:0] exp;
            tick();
            exp = {18'(4 + i / 3), (i < 3) ? 16'hBEEF : 16'hDEAD, i % 3 == 2, 1'b1, 1'b0};
            checks++;
            if ({sram_addr, dq, we_n, oe_n, ready} !== exp) begin
                errors++; $display("FAIL wr_cycle%0d got=%h exp=%h", i, {sram_addr, dq, we_n, oe_n, ready}, exp);
            end
        end
        tick();
        checks++; if ({ready, we_n, sram_addr} !== {2'b11, 18'd4}) begin errors++; $display("FAIL wr_done got=%b/%b/%h exp=1/1/4", ready, we_n, sram_addr); end
        wr_en = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready got=%b exp=1", ready); end
        checks++; if ({mem[5], mem[4]} !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got=%h exp=deadbeef", {mem[5], mem[4]}); end
    endtask

    task automatic test_read;
        mem[4] = 16'h1234; mem[5] = 16'hABCD;
        address = 32'd1032; rd_en = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd_req_ready got=%b exp=0", ready); end
        for (int i = 0; i < 6; i++) begin
            logic [36:0] exp;
            tick();
            exp = {18'(4 + i / 3), (i < 3) ? 16'h1234 : 16'hABCD, 1'b1, 1'b0, 1'b0};
            checks++;
            if ({sram_addr, dq, we_n, oe_n, ready} !== exp) begin
                errors++; $display("FAIL rd_cycle%0d got=%h exp=%h", i, {sram_addr, dq, we_n, oe_n, ready}, exp);
            end
        end
        checks++; if (readData !== 32'd0) begin errors++; $display("FAIL rd_early got=%h exp=0", readData); end
        tick();
        checks++; if ({ready, oe_n} !== 2'b11) begin errors++; $display("FAIL rd_done got=%b exp=11", {ready, oe_n}); end
        checks++; if (readData !== 32'hABCD1234) begin errors++; $display("FAIL rd_data got=%h exp=abcd1234", readData); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_priority;
        address = 32'd1048; writeData = 32'h55AA0FF0; wr_en = 1'b1; rd_en = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pri_req_ready got=%b exp=0", ready); end
        for (int i = 0; i < 6; i++) begin
            logic [35:0] exp;
            tick();
            exp = {18'(12 + i / 3), (i < 3) ? 16'h0FF0 : 16'h55AA, i % 3 == 2, 1'b1};
            checks++;
            if ({sram_addr, dq, we_n, oe_n} !== exp) begin
                errors++; $display("FAIL pri_cycle%0d got=%h exp=%h", i, {sram_addr, dq, we_n, oe_n}, exp);
            end
        end
        tick();
        checks++; if ({ready, readData} !== {1'b1, 32'hABCD1234}) begin errors++; $display("FAIL pri_done got=%b/%h exp=1/abcd1234", ready, readData); end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        checks++; if ({mem[13], mem[12]} !== 32'h55AA0FF0) begin errors++; $display("FAIL pri_mem got=%h exp=55aa0ff0", {mem[13], mem[12]}); end
    endtask

    task automatic test_back_to_back;
        address = 32'd1064; writeData = 32'hCAFEF00D; wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({we_n, oe_n} !== {i % 3 == 2, 1'b1}) begin
                errors++; $display("FAIL b2b_wr%0d got=%b exp=%b1", i, {we_n, oe_n}, i % 3 == 2);
            end
        end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", ready); end
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        checks++; if ({ready, oe_n} !== 2'b01) begin errors++; $display("FAIL b2b_idle got=%b exp=01", {ready, oe_n}); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({sram_addr, oe_n, ready} !== {18'(20 + i / 3), 2'b00}) begin
                errors++; $display("FAIL b2b_rd%0d got=%h/%b/%b exp=%h/0/0", i, sram_addr, oe_n, ready, 20 + i / 3);
            end
        end
        tick();
        checks++; if ({ready, readData} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL b2b_data got=%b/%h exp=1/cafef00d", ready, readData); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        address = 32'd1072; writeData = 32'h11112222; wr_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({sram_addr, we_n} !== {18'd25, 1'b0}) begin errors++; $display("FAIL mid_pre got=%h/%b exp=19/0", sram_addr, we_n); end
        rst = 1'b0; wr_en = 1'b0;
        #1;
        checks++; if ({ready, we_n, oe_n} !== 3'b111) begin errors++; $display("FAIL mid_ctrl got=%b exp=111", {ready, we_n, oe_n}); end
        checks++; if ({sram_addr, readData} !== 50'd0) begin errors++; $display("FAIL mid_regs got=%h/%h exp=0/0", sram_addr, readData); end
        checks++; if (mem[24] !== 16'h2222) begin errors++; $display("FAIL mid_partial got=%h exp=2222", mem[24]); end
        tick();
        tick();
        checks++; if ({ready, we_n, oe_n} !== 3'b111) begin errors++; $display("FAIL mid_hold got=%b exp=111", {ready, we_n, oe_n}); end
        rst = 1'b1;
        tick();
        address = 32'd1032; rd_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({oe_n, readData} !== {1'b0, 32'd0}) begin errors++; $display("FAIL mid_rd_busy got=%b/%h exp=0/0", oe_n, readData); end
        tick();
        checks++; if ({ready, readData} !== {1'b1, 32'hABCD1234}) begin errors++; $display("FAIL mid_rd_data got=%b/%h exp=1/abcd1234", ready, readData); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wait_wrap;
        address2 = 32'd1020; rd2 = 1'b1;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL w2_req_ready got=%b exp=0", ready2); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({ready2, sram_addr2} !== {1'b0, (i < 2) ? 18'h3FFFE : 18'h3FFFF}) begin
                errors++; $display("FAIL w2_cycle%0d got=%b/%h exp=0/%h", i, ready2, sram_addr2, (i < 2) ? 18'h3FFFE : 18'h3FFFF);
            end
        end
        tick();
        checks++; if ({ready2, readData2} !== {1'b1, 32'h5A5A5A5A}) begin errors++; $display("FAIL w2_done got=%b/%h exp=1/5a5a5a5a", ready2, readData2); end
        rd2 = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        #1 rst = 1'b0;
        #1;
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_wait_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
